// File: rtl/scalar_writeback_arbiter_if.sv
// Writeback bus between the two scalar writeback sources, the arbiter and the
// register-file write port.
interface scalar_writeback_arbiter_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned WIDTH = 32
);
  logic             alu_valid;
  logic             alu_ready;
  logic [AW-1:0]    alu_addr;
  logic [WIDTH-1:0] alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic             freeze;
  logic             we3;
  logic [AW-1:0]    a3;
  logic [WIDTH-1:0] wd3;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output freeze,
    input  alu_ready, mem_ready,
    input  we3, a3, wd3
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  freeze,
    output alu_ready, mem_ready,
    output we3, a3, wd3
  );
endinterface

// File: rtl/scalar_writeback_arbiter.sv
// Round-robin arbiter sharing the scalar register-file write port between the
// ALU and load-return writeback paths, with a registered write stage.
module scalar_writeback_arbiter #(
  parameter int unsigned REGISTERS = 32,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scalar_writeback_arbiter_if.slave wb,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);
  localparam int unsigned AW = $clog2(REGISTERS);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  grant_e               last_grant_q, last_grant_d;
  logic                 we3_q, we3_d;
  logic [AW-1:0]        a3_q, a3_d;
  logic [WIDTH-1:0]     wd3_q, wd3_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 alu_gnt_c, mem_gnt_c;
  logic                 both_valid_c;

  // Grant decision; on a tie the source not granted most recently wins.
  always_comb begin
    alu_gnt_c = 1'b0;
    mem_gnt_c = 1'b0;
    if (rst_n && !wb.freeze) begin
      if (wb.alu_valid && (!wb.mem_valid || last_grant_q == GNT_MEM)) begin
        alu_gnt_c = 1'b1;
      end else if (wb.mem_valid) begin
        mem_gnt_c = 1'b1;
      end
    end
  end

  assign both_valid_c = wb.alu_valid && wb.mem_valid && !wb.freeze;

  // Next-state: grant history, write stage and contention counter.
  always_comb begin
    last_grant_d = last_grant_q;
    we3_d        = 1'b0;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    cnt_d        = cnt_q;
    if (alu_gnt_c) begin
      last_grant_d = GNT_ALU;
      a3_d         = AW'(wb.alu_addr);
      wd3_d        = WIDTH'(wb.alu_data);
      we3_d        = (wb.alu_addr != '0);
    end else if (mem_gnt_c) begin
      last_grant_d = GNT_MEM;
      a3_d         = AW'(wb.mem_addr);
      wd3_d        = WIDTH'(wb.mem_data);
      we3_d        = (wb.mem_addr != '0);
    end
    if (both_valid_c && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_MEM;
      we3_q        <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wb.alu_ready  = alu_gnt_c;
  assign wb.mem_ready  = mem_gnt_c;
  assign wb.we3        = we3_q;
  assign wb.a3         = a3_q;
  assign wb.wd3        = wd3_q;
  assign conflict_cnt  = cnt_q;
endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Self-checking bench for scalar_writeback_arbiter: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_scalar_writeback_arbiter;
  localparam int unsigned AW    = 5;
  localparam int unsigned WIDTH = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  scalar_writeback_arbiter_if #(.AW(AW), .WIDTH(WIDTH)) bus ();
  scalar_writeback_arbiter_if #(.AW(AW), .WIDTH(WIDTH)) bus_s ();

  // Second instance with a narrow counter sees identical stimulus.
  assign bus_s.alu_valid = bus.alu_valid;
  assign bus_s.alu_addr  = bus.alu_addr;
  assign bus_s.alu_data  = bus.alu_data;
  assign bus_s.mem_valid = bus.mem_valid;
  assign bus_s.mem_addr  = bus.mem_addr;
  assign bus_s.mem_data  = bus.mem_data;
  assign bus_s.freeze    = bus.freeze;

  scalar_writeback_arbiter #(.REGISTERS(32), .WIDTH(WIDTH), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb(bus.slave), .conflict_cnt(cnt16));

  scalar_writeback_arbiter #(.REGISTERS(32), .WIDTH(WIDTH), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .wb(bus_s.slave), .conflict_cnt(cnt4));

  typedef struct {
    logic        av, mv, fz;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ar, mr, we;
    logic [4:0]  a3;
    logic [31:0] wd;
    int          cnt;
  } vec_t;

  vec_t tbl [12];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic mv, input logic fz,
                       input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] ma, input logic [31:0] md);
    bus.alu_valid = av;
    bus.mem_valid = mv;
    bus.freeze    = fz;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
  endtask

  function automatic vec_t mk(input logic av, input logic mv, input logic fz,
                              input logic [4:0] aa, input logic [31:0] ad,
                              input logic [4:0] ma, input logic [31:0] md,
                              input logic ar, input logic mr, input logic we,
                              input logic [4:0] a3, input logic [31:0] wd, input int cnt);
    vec_t v;
    v.av = av; v.mv = mv; v.fz = fz; v.aa = aa; v.ad = ad; v.ma = ma; v.md = md;
    v.ar = ar; v.mr = mr; v.we = we; v.a3 = a3; v.wd = wd; v.cnt = cnt;
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Behavioural model state for the random phase.
  bit          m_last_alu;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          m_cnt;

  initial begin
    logic        av, mv, fz, xa, xm, ga, gm;
    logic [4:0]  aa, ma;
    logic [31:0] ad, md;

    tbl[0]  = mk(1, 0, 0, 5, 32'hDEADBEEF, 0, 0,    1, 0, 1, 5, 32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0,            0, 0,    0, 0, 0, 5, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0,            0, 'h1234, 0, 1, 0, 0, 'h1234, 0);
    tbl[3]  = mk(1, 1, 0, 1, 'h11,         2, 'h22, 1, 0, 1, 1, 'h11, 1);
    tbl[4]  = mk(1, 1, 0, 3, 'h33,         2, 'h22, 0, 1, 1, 2, 'h22, 2);
    tbl[5]  = mk(1, 1, 0, 3, 'h33,         4, 'h44, 1, 0, 1, 3, 'h33, 3);
    tbl[6]  = mk(1, 1, 0, 5, 'h55,         4, 'h44, 0, 1, 1, 4, 'h44, 4);
    tbl[7]  = mk(1, 1, 1, 5, 'h55,         6, 'h66, 0, 0, 0, 4, 'h44, 4);
    tbl[8]  = mk(1, 1, 1, 5, 'h55,         6, 'h66, 0, 0, 0, 4, 'h44, 4);
    tbl[9]  = mk(1, 1, 1, 5, 'h55,         6, 'h66, 0, 0, 0, 4, 'h44, 4);
    tbl[10] = mk(1, 1, 0, 5, 'h55,         6, 'h66, 1, 0, 1, 5, 'h55, 5);
    tbl[11] = mk(0, 1, 0, 0, 0,            6, 'h66, 0, 1, 1, 6, 'h66, 5);

    // Reset with ALU valid: ready must stay low and outputs clear.
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'h3, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we3", 32'(bus.we3), 0);
    chk("rst_a3", 32'(bus.a3), 0);
    chk("rst_wd3", bus.wd3, 0);
    chk("rst_cnt", 32'(cnt16), 0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].mv, tbl[i].fz, tbl[i].aa, tbl[i].ad, tbl[i].ma, tbl[i].md);
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), 32'(bus.alu_ready), 32'(tbl[i].ar));
      chk($sformatf("tbl%0d_mem_ready", i), 32'(bus.mem_ready), 32'(tbl[i].mr));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_we3", i), 32'(bus.we3), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_a3", i), 32'(bus.a3), 32'(tbl[i].a3));
      chk($sformatf("tbl%0d_wd3", i), bus.wd3, tbl[i].wd);
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt16), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_cnt4", i), 32'(cnt4), 32'(sat(tbl[i].cnt, 15)));
    end

    // Reset mid-write: in-flight write dropped without a clock edge.
    chk("mid_we3_before", 32'(bus.we3), 1);
    drive(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 5'd8, 32'h88);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_we3", 32'(bus.we3), 0);
    chk("mid_a3", 32'(bus.a3), 0);
    chk("mid_wd3", bus.wd3, 0);
    chk("mid_cnt", 32'(cnt16), 0);
    chk("mid_cnt4", 32'(cnt4), 0);
    chk("mid_alu_ready", 32'(bus.alu_ready), 0);
    chk("mid_mem_ready", 32'(bus.mem_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_alu_ready", 32'(bus.alu_ready), 1);
    chk("post_rst_mem_ready", 32'(bus.mem_ready), 0);
    @(posedge clk);
    #1;
    chk("post_rst_we3", 32'(bus.we3), 1);
    chk("post_rst_a3", 32'(bus.a3), 7);
    chk("post_rst_wd3", bus.wd3, 32'h77);

    // Saturation and strict alternation under continuous contention.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 5'd10, 32'hAA);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("sat%0d_alu_ready", i), 32'(bus.alu_ready), 32'((i % 2) == 0));
      chk($sformatf("sat%0d_mem_ready", i), 32'(bus.mem_ready), 32'((i % 2) == 1));
      @(negedge clk);
    end
    chk("sat_cnt16", 32'(cnt16), 20);
    chk("sat_cnt4", 32'(cnt4), 15);

    // Randomized traffic against the behavioural model.
    do_reset();
    m_last_alu = 1'b0; m_we = 1'b0; m_a3 = '0; m_wd = '0; m_cnt = 0;
    av = 0; mv = 0; aa = 0; ma = 0; ad = 0; md = 0; xa = 0; xm = 0;
    for (int c = 0; c < 400; c++) begin
      if (!av || xa) begin
        av = ($urandom_range(99) < 65);
        aa = 5'($urandom_range(31));
        ad = $urandom;
      end
      if (!mv || xm) begin
        mv = ($urandom_range(99) < 65);
        ma = 5'($urandom_range(31));
        md = $urandom;
      end
      fz = ($urandom_range(99) < 10);
      drive(av, mv, fz, aa, ad, ma, md);
      ga = 0; gm = 0;
      if (!fz) begin
        if (av && mv) begin
          if (m_last_alu) gm = 1; else ga = 1;
        end else if (av) ga = 1;
        else if (mv) gm = 1;
      end
      #1;
      chk("rnd_alu_ready", 32'(bus.alu_ready), 32'(ga));
      chk("rnd_mem_ready", 32'(bus.mem_ready), 32'(gm));
      @(posedge clk);
      if (ga) begin m_last_alu = 1; m_a3 = aa; m_wd = ad; m_we = (aa != 0); end
      else if (gm) begin m_last_alu = 0; m_a3 = ma; m_wd = md; m_we = (ma != 0); end
      else m_we = 0;
      if (av && mv && !fz) m_cnt = m_cnt + 1;
      xa = ga; xm = gm;
      #1;
      chk("rnd_we3", 32'(bus.we3), 32'(m_we));
      chk("rnd_a3", 32'(bus.a3), 32'(m_a3));
      chk("rnd_wd3", bus.wd3, m_wd);
      chk("rnd_cnt16", 32'(cnt16), 32'(sat(m_cnt, 65535)));
      chk("rnd_cnt4", 32'(cnt4), 32'(sat(m_cnt, 15)));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
